// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side handshake and data-memory bus shared by the
// dual-requester data-memory arbiter and its environment.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, done0, done1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic              mem_rd, mem_wr;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, done0, done1, rdata, mem_addr, mem_din, mem_rd, mem_wr
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, done0, done1, rdata, mem_addr, mem_din, mem_rd, mem_wr
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter giving two requesters a five-state,
// fully registered access sequence to a single data memory.
module dmem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, DONE} state_t;
  state_t            state, next;
  logic              last, own, we_q, win, go;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next     = state;
    go       = 1'b0;
    win      = (bus.req0 & bus.req1) ? ~last : bus.req1;
    sel_addr = win ? bus.addr1 : bus.addr0;
    sel_din  = win ? bus.wdata1 : bus.wdata0;
    case (state)
      IDLE: begin
        go   = bus.req0 | bus.req1;
        next = go ? SETUP : IDLE;
      end
      SETUP:   next = STROBE;
      STROBE:  next = CAPTURE;
      CAPTURE: next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  // mem_addr/mem_din double as the transaction latches, so they hold between transactions
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last         <= 1'b1;
      own          <= 1'b0;
      we_q         <= 1'b0;
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.done0    <= 1'b0;
      bus.done1    <= 1'b0;
      bus.mem_rd   <= 1'b0;
      bus.mem_wr   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      bus.rdata    <= '0;
    end else begin
      bus.mem_rd <= (state == SETUP) && !we_q;
      bus.mem_wr <= (state == SETUP) && we_q;
      bus.done0  <= (state == CAPTURE) && !own;
      bus.done1  <= (state == CAPTURE) && own;
      if (go) begin
        last         <= win;
        own          <= win;
        we_q         <= win ? bus.we1 : bus.we0;
        bus.mem_addr <= sel_addr;
        bus.mem_din  <= sel_din;
        bus.gnt0     <= !win;
        bus.gnt1     <= win;
      end
      if (state == DONE) begin
        bus.gnt0 <= 1'b0;
        bus.gnt1 <= 1'b0;
      end
      if (state == CAPTURE && !we_q) bus.rdata <= bus.mem_dout;
    end
endmodule
